snail_bit_serializer: RTL and testbench

- Upstream feeder for the serial two-consecutive-ones detector.
- Accepts parallel words over a valid/ready handshake.
- Shifts each word out MSB-first on a single-bit serial line, one bit per BIT_CYCLES clocks.
- Holds the line at 0 between words, so every word starts from the detector's idle/"no ones" condition.

---
 rtl/snail_bit_serializer.sv | 118 +++++++++++
 tb/tb_snail_bit_serializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/snail_bit_serializer.sv
// MSB-first parallel-to-serial feeder with valid/ready intake and forced-zero inter-word gap.
// Optional SERIAL_PARITY_EN appends an even-parity bit after the LSB of every word.
module snail_bit_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned GAP        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_d,
  output logic             ser_active,
  output logic             done
);

`ifdef SERIAL_PARITY_EN
  localparam int unsigned NB = WIDTH + 1;
`else
  localparam int unsigned NB = WIDTH;
`endif
  localparam int unsigned CYC_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BIT_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NB-1:0]    sh_q, sh_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             act_q, act_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      act_q   <= act_d;
      done_q  <= done_d;
    end
  end

  // Shifting zeros in behind the data leaves the register clear once the last bit is gone.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    act_d   = act_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        act_d = 1'b0;
        if (in_valid) begin
          state_d = S_SHIFT;
`ifdef SERIAL_PARITY_EN
          sh_d    = {in_data, ^in_data};
`else
          sh_d    = in_data;
`endif
          cyc_d   = '0;
          bit_d   = '0;
          act_d   = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cyc_q == CYC_W'(BIT_CYCLES - 1)) begin
          cyc_d = '0;
          sh_d  = sh_q << 1;
          if (bit_q == BIT_W'(NB - 1)) begin
            act_d  = 1'b0;
            done_d = 1'b1;
            gap_d  = '0;
            state_d = (GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign ser_d      = sh_q[NB-1];
  assign ser_active = act_q;
  assign done       = done_q;

endmodule

// File: tb/tb_snail_bit_serializer.sv
// Scoreboard bench for snail_bit_serializer: three configurations, expected cycle streams queued at accept.
module tb_snail_bit_serializer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, in_valid, in_ready, ser_d, ser_active, done;
  logic [7:0] in_data [3];
  int checks = 0;
  int fails  = 0;

`ifdef SERIAL_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef struct packed {
    logic d;
    logic act;
    logic dn;
    logic rdy;
  } obs_t;

  obs_t exp_q[$];

  snail_bit_serializer #(.WIDTH(8), .BIT_CYCLES(1), .GAP(2)) u0 (
    .clk(clk), .rst(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_d(ser_d[0]), .ser_active(ser_active[0]), .done(done[0]));
  snail_bit_serializer #(.WIDTH(8), .BIT_CYCLES(1), .GAP(0)) u1 (
    .clk(clk), .rst(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_d(ser_d[1]), .ser_active(ser_active[1]), .done(done[1]));
  snail_bit_serializer #(.WIDTH(8), .BIT_CYCLES(3), .GAP(0)) u2 (
    .clk(clk), .rst(rst[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .ser_d(ser_d[2]), .ser_active(ser_active[2]), .done(done[2]));

  function automatic obs_t observe(input int u);
    return {ser_d[u], ser_active[u], done[u], in_ready[u]};
  endfunction

  // Expected per-cycle stream from the cycle after the accepting edge up to the next ready cycle.
  function automatic void push_word(input logic [7:0] data, input int bc, input int gap);
    logic b;
    for (int i = 0; i < NB; i++) begin
      b = (i < 8) ? data[7-i] : ^data;
      for (int c = 0; c < bc; c++) exp_q.push_back({b, 1'b1, 1'b0, 1'b0});
    end
    exp_q.push_back({1'b0, 1'b0, 1'b1, (gap == 0)});
    for (int g = 1; g < gap; g++) exp_q.push_back(4'b0000);
    if (gap > 0) exp_q.push_back(4'b0001);
  endfunction

  task automatic test_reset();
    obs_t got;
    rst = 3'b111;
    in_valid = 3'b001;
    for (int u = 0; u < 3; u++) in_data[u] = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      got = observe(0);
      checks++;
      if (got !== 4'b0000) begin
        fails++;
        $display("FAIL reset cycle %0d: got d/act/done/rdy=%b expected 0000", n, got);
      end
    end
    rst = 3'b000;
    in_valid = 3'b000;
    #1;
    got = observe(0);
    checks++;
    if (got !== 4'b0001) begin
      fails++;
      $display("FAIL reset_release: got d/act/done/rdy=%b expected 0001", got);
    end
    @(negedge clk);
    got = observe(0);
    checks++;
    if (got !== 4'b0001) begin
      fails++;
      $display("FAIL reset_no_accept: got d/act/done/rdy=%b expected 0001", got);
    end
  endtask

  task automatic test_word(input string name, input int u, input logic [7:0] data,
                           input int bc, input int gap);
    obs_t got, e;
    @(negedge clk);
    in_data[u] = data;
    in_valid[u] = 1'b1;
    #1;
    checks++;
    if (in_ready[u] !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_before_accept: got %b expected 1", name, in_ready[u]);
    end
    @(posedge clk);
    push_word(data, bc, gap);
    #1 in_valid[u] = 1'b0;
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      got = observe(u);
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL %s cycle %0d: got d/act/done/rdy=%b expected %b", name, n + 1, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, e;
    @(negedge clk);
    in_data[1] = 8'hFF;
    in_valid[1] = 1'b1;
    @(posedge clk);
    push_word(8'hFF, 1, 0);
    push_word(8'hFF, 1, 0);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      got = observe(1);
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL back_to_back cycle %0d: got d/act/done/rdy=%b expected %b", n + 1, got, e);
      end
      if (n == NB + 1) in_valid[1] = 1'b0;
    end
  endtask

  task automatic test_abort();
    obs_t got, e;
    @(negedge clk);
    in_data[0] = 8'hFF;
    in_valid[0] = 1'b1;
    @(posedge clk);
    push_word(8'hFF, 1, 2);
    #1 in_valid[0] = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      got = observe(0);
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL abort_prefix cycle %0d: got d/act/done/rdy=%b expected %b", n + 1, got, e);
      end
    end
    rst[0] = 1'b1;
    exp_q.delete();
    @(negedge clk);
    got = observe(0);
    checks++;
    if (got !== 4'b0000) begin
      fails++;
      $display("FAIL abort_flush: got d/act/done/rdy=%b expected 0000", got);
    end
    rst[0] = 1'b0;
    in_data[0] = 8'h01;
    in_valid[0] = 1'b1;
    #1;
    got = observe(0);
    checks++;
    if (got !== 4'b0001) begin
      fails++;
      $display("FAIL abort_release: got d/act/done/rdy=%b expected 0001", got);
    end
    @(posedge clk);
    push_word(8'h01, 1, 2);
    #1 in_valid[0] = 1'b0;
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      got = observe(0);
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL abort_next cycle %0d: got d/act/done/rdy=%b expected %b", n + 1, got, e);
      end
    end
  endtask

  initial begin
    rst = 3'b111;
    in_valid = 3'b000;
    test_reset();
    test_word("single_B6", 0, 8'hB6, 1, 2);
    test_back_to_back();
    test_word("stretched_80", 2, 8'h80, 3, 0);
    test_abort();
    test_word("parity_07", 0, 8'h07, 1, 2);
    test_word("parity_03", 0, 8'h03, 1, 2);
    test_word("b2b_idle_07", 1, 8'h07, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
